// File: rtl/datamover_job_scheduler_pkg.sv
// Shared types for the datamover job scheduler: job descriptor
// layout and scheduler FSM state encoding.
package datamover_job_scheduler_pkg;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] tot_len;
    logic [31:0] in_d0_len;
    logic [31:0] in_d0_stride;
    logic [31:0] in_d1_len;
    logic [31:0] in_d1_stride;
    logic [31:0] in_d2_stride;
    logic [31:0] out_d0_len;
    logic [31:0] out_d0_stride;
    logic [31:0] out_d1_len;
    logic [31:0] out_d1_stride;
    logic [31:0] out_d2_stride;
  } job_desc_t;

  localparam int unsigned JOB_W = $bits(job_desc_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WORK,
    ST_DONE,
    ST_ABORT
  } dm_sched_state_t;

endpackage

// File: rtl/datamover_job_scheduler_if.sv
// Job submission handshake: valid/ready plus descriptor and tag.
// master drives valid/job/tag, slave (scheduler) drives ready.
interface datamover_job_scheduler_if
  import datamover_job_scheduler_pkg::*;
#(
  parameter int unsigned TAG_W = 8
) ();

  logic             valid;
  logic             ready;
  job_desc_t        job;
  logic [TAG_W-1:0] tag;

  modport master (
    output valid,
    output job,
    output tag,
    input  ready
  );

  modport slave (
    input  valid,
    input  job,
    input  tag,
    output ready
  );

endinterface

// File: rtl/datamover_job_scheduler_fifo.sv
// Job queue: DEPTH x W entries, push/pop/flush, full/empty/level.
// Ports: clk_i, rst_ni, flush_i, push_i, pop_i, data_i, data_o, full_o, empty_o, level_o.
module datamover_job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [LW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // Flush wins over a same-cycle push.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/datamover_job_scheduler.sv
// Queues job descriptors and runs them back-to-back on one streamer,
// with completion tags and a watchdog abort.
// Ports: clk_i/rst_ni/clear_i, job_if (valid/ready/job/tag), timeout_i,
// sink_done_i, tcdm_fifo_empty_i; pulses src/snk_start_o, done_o, err_o,
// abort_o; cur_job_o, done_tag_o, busy_o, level_o.
module datamover_job_scheduler
  import datamover_job_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned TMO_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  datamover_job_scheduler_if.slave   job_if,
  input  logic [TMO_W-1:0]           timeout_i,
  input  logic                       sink_done_i,
  input  logic                       tcdm_fifo_empty_i,
  output logic                       src_start_o,
  output logic                       snk_start_o,
  output job_desc_t                  cur_job_o,
  output logic                       abort_o,
  output logic                       done_o,
  output logic [TAG_W-1:0]           done_tag_o,
  output logic                       err_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int unsigned EW = JOB_W + TAG_W;

  dm_sched_state_t  state_q, state_d;
  logic [TMO_W-1:0] wd_q, wd_d;
  job_desc_t        cur_job_q;
  logic [TAG_W-1:0] tag_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic [EW-1:0]    fifo_wdata;
  logic [EW-1:0]    fifo_rdata;
  job_desc_t        head_job;
  logic [TAG_W-1:0] head_tag;
  logic             push_fire;
  logic             pop;
  logic             load;
  logic             wd_hit;

  assign job_if.ready = ~fifo_full;
  assign push_fire    = job_if.valid & ~fifo_full;
  assign fifo_wdata   = {job_if.job, job_if.tag};
  assign head_job     = fifo_rdata[EW-1:TAG_W];
  assign head_tag     = fifo_rdata[TAG_W-1:0];

  datamover_job_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (job_if.valid),
    .pop_i   (pop),
    .data_i  (fifo_wdata),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign wd_hit = (timeout_i != '0) &&
                  (wd_q == timeout_i - TMO_W'(1));

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    pop     = 1'b0;
    load    = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      wd_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // A push this cycle lands in the queue before LOAD pops it.
          if (!fifo_empty || push_fire) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          pop  = 1'b1;
          load = 1'b1;
          if (head_job.tot_len == '0) state_d = ST_DONE;
          else                        state_d = ST_START;
        end
        ST_START: begin
          wd_d    = '0;
          state_d = ST_WORK;
        end
        ST_WORK: begin
          if (wd_q != '1) wd_d = wd_q + TMO_W'(1);
          if (sink_done_i && tcdm_fifo_empty_i) state_d = ST_DONE;
          else if (wd_hit)                      state_d = ST_ABORT;
        end
        ST_DONE: begin
          if (!fifo_empty) state_d = ST_LOAD;
          else             state_d = ST_IDLE;
        end
        ST_ABORT: begin
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_job_q <= '0;
      tag_q     <= '0;
    end else if (load) begin
      cur_job_q <= head_job;
      tag_q     <= head_tag;
    end
  end

  assign cur_job_o   = cur_job_q;
  assign src_start_o = (state_q == ST_START);
  assign snk_start_o = (state_q == ST_START);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = (state_q == ST_ABORT);
  assign abort_o     = (state_q == ST_ABORT);
  assign done_tag_o  = (done_o | err_o) ? tag_q : '0;
  assign busy_o      = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_datamover_job_scheduler.sv
// Self-checking bench for datamover_job_scheduler: scoreboard of
// expected completion tags, plus latency/gap checks on pulse cycles.
module tb_datamover_job_scheduler;
  import datamover_job_scheduler_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 8;
  localparam int TMO_W = 32;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             clear_i = 1'b0;
  logic [TMO_W-1:0] timeout_i = '0;
  logic             sink_done_i = 1'b0;
  logic             tcdm_fifo_empty_i = 1'b1;
  logic             src_start_o;
  logic             snk_start_o;
  job_desc_t        cur_job_o;
  logic             abort_o;
  logic             done_o;
  logic [TAG_W-1:0] done_tag_o;
  logic             err_o;
  logic             busy_o;
  logic [2:0]       level_o;

  datamover_job_scheduler_if #(.TAG_W(TAG_W)) jif ();

  always #5 clk_i = ~clk_i;

  datamover_job_scheduler #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .TMO_W (TMO_W)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .clear_i           (clear_i),
    .job_if            (jif),
    .timeout_i         (timeout_i),
    .sink_done_i       (sink_done_i),
    .tcdm_fifo_empty_i (tcdm_fifo_empty_i),
    .src_start_o       (src_start_o),
    .snk_start_o       (snk_start_o),
    .cur_job_o         (cur_job_o),
    .abort_o           (abort_o),
    .done_o            (done_o),
    .done_tag_o        (done_tag_o),
    .err_o             (err_o),
    .busy_o            (busy_o),
    .level_o           (level_o)
  );

  typedef struct packed {
    logic [7:0] tag;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   st_cyc[$];
  int   evt_cyc[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_abort = 0;
  exp_t e;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  nm, got, exp);
  endtask

  function automatic job_desc_t mk(input logic [31:0] len,
                                   input logic [7:0] tag);
    job_desc_t j;
    j = '0;
    j.src_addr   = {24'h100000, tag};
    j.dst_addr   = {24'h200000, tag};
    j.tot_len    = len;
    j.in_d0_len  = len;
    j.out_d0_len = len;
    return j;
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (src_start_o || snk_start_o) begin
        chk("start_pair", snk_start_o, src_start_o);
        st_cyc.push_back(cyc);
      end
      if (abort_o) n_abort++;
      if (done_o || err_o) begin
        chk("abort_eq_err", abort_o, err_o);
        if (sb.size() == 0) begin
          chk("unexpected_evt", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("evt_tag", done_tag_o, e.tag);
          chk("evt_kind", err_o, e.err);
        end
        evt_cyc.push_back(cyc);
      end
    end
  end

  task automatic push_job(input logic [31:0] len,
                          input logic [7:0] tag,
                          input logic err,
                          input bit track,
                          output int t);
    int k;
    k = 0;
    @(posedge clk_i); #1;
    jif.valid = 1'b1;
    jif.job   = mk(len, tag);
    jif.tag   = tag;
    while (!jif.ready && k < 200) begin
      @(posedge clk_i); #1;
      k++;
    end
    chk("push_ready", k < 200, 1);
    t = cyc;
    if (track) sb.push_back('{tag, err});
    @(posedge clk_i); #1;
    jif.valid = 1'b0;
  endtask

  task automatic wait_starts(input int n, input string nm);
    int k;
    k = 0;
    while (st_cyc.size() < n && k < 400) begin
      @(negedge clk_i); #1;
      k++;
    end
    chk(nm, st_cyc.size(), n);
  endtask

  task automatic wait_evts(input int n, input string nm);
    int k;
    k = 0;
    while (evt_cyc.size() < n && k < 400) begin
      @(negedge clk_i); #1;
      k++;
    end
    chk(nm, evt_cyc.size(), n);
  endtask

  task automatic clr_q();
    st_cyc.delete();
    evt_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int t2;
    int s;
    jif.valid = 1'b0;
    jif.job   = '0;
    jif.tag   = '0;

    // Reset state, sampled while reset is still asserted
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", jif.ready, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_start", src_start_o, 0);
    chk("rst_tag", done_tag_o, 0);
    chk("rst_cur", cur_job_o.tot_len, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Single job, sink done 20 cycles into WORK
    clr_q();
    push_job(16, 8'h11, 0, 1, t);
    wait_starts(1, "t1_start");
    s = st_cyc[0];
    chk("t1_lat", s, t + 2);
    chk("t1_curlen", cur_job_o.tot_len, 16);
    chk("t1_cursrc", cur_job_o.src_addr, 32'h1000_0011);
    repeat (20) @(posedge clk_i);
    #1;
    sink_done_i = 1'b1;
    @(posedge clk_i); #1;
    sink_done_i = 1'b0;
    wait_evts(1, "t1_done");
    chk("t1_done_lat", evt_cyc[0], s + 21);
    @(negedge clk_i); #1;
    chk("t1_pulse", done_o, 0);
    chk("t1_hold", cur_job_o.tot_len, 16);
    chk("t1_idle", busy_o, 0);

    // Fill the queue behind a running job, then drain
    clr_q();
    push_job(8, 8'h20, 0, 1, t);
    wait_starts(1, "t2_start0");
    for (int i = 1; i <= 4; i++) begin
      push_job(8, 8'(i), 0, 1, t);
    end
    chk("t2_full_ready", jif.ready, 0);
    chk("t2_level", level_o, 4);
    chk("t2_busy", busy_o, 1);
    sink_done_i = 1'b1;
    wait_evts(5, "t2_done");
    sink_done_i = 1'b0;
    chk("t2_starts", st_cyc.size(), 5);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_gap", st_cyc[i] - evt_cyc[i-1], 2);
      chk("t2_run", evt_cyc[i] - st_cyc[i], 2);
    end

    // Zero-length job completes without a start pulse
    clr_q();
    push_job(0, 8'h07, 0, 1, t);
    wait_evts(1, "t3_done");
    chk("t3_lat", evt_cyc[0], t + 2);
    chk("t3_nostart", st_cyc.size(), 0);

    // Watchdog abort, then the queued job runs
    clr_q();
    timeout_i = 50;
    push_job(4, 8'h30, 1, 1, t);
    wait_starts(1, "t4_start");
    s = st_cyc[0];
    push_job(4, 8'h31, 0, 1, t2);
    wait_evts(1, "t4_abort");
    chk("t4_abort_lat", evt_cyc[0], s + 51);
    wait_starts(2, "t4_next");
    timeout_i = 0;
    chk("t4_next_lat", st_cyc[1] - evt_cyc[0], 3);
    chk("t4_nabort", n_abort, 1);
    sink_done_i = 1'b1;
    wait_evts(2, "t4_done2");
    sink_done_i = 1'b0;

    // sink_done waits for the TCDM fifo to drain
    clr_q();
    push_job(4, 8'h40, 0, 1, t);
    wait_starts(1, "t5_start");
    s = st_cyc[0];
    @(posedge clk_i); #1;
    sink_done_i = 1'b1;
    tcdm_fifo_empty_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("t5_nodone", evt_cyc.size(), 0);
    tcdm_fifo_empty_i = 1'b1;
    wait_evts(1, "t5_done");
    sink_done_i = 1'b0;
    chk("t5_lat", evt_cyc[0], s + 5);

    // Clear mid-WORK with two queued; same-cycle push dropped
    clr_q();
    push_job(4, 8'h50, 0, 0, t);
    wait_starts(1, "t6_start");
    push_job(4, 8'h51, 0, 0, t);
    push_job(4, 8'h52, 0, 0, t);
    chk("t6_level", level_o, 2);
    @(posedge clk_i); #1;
    clear_i   = 1'b1;
    jif.valid = 1'b1;
    jif.job   = mk(4, 8'h5F);
    jif.tag   = 8'h5F;
    @(posedge clk_i); #1;
    clear_i   = 1'b0;
    jif.valid = 1'b0;
    chk("t6_level0", level_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_ready", jif.ready, 1);
    repeat (20) @(negedge clk_i);
    #1;
    chk("t6_noevt", evt_cyc.size(), 0);
    chk("t6_nostart", st_cyc.size(), 1);
    chk("t6_noabort", n_abort, 1);
    push_job(0, 8'h60, 0, 1, t);
    wait_evts(1, "t6_after");
    chk("t6_after_lat", evt_cyc[0], t + 2);

    @(negedge clk_i); #1;
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
